// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: FSM state encoding
// and the operand-forwarding mux select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int CNT_W = 4;

endpackage

// File: rtl/hazard_if.sv
// Bundle of pipeline-register request fields and the stall/flush/forward
// controls exchanged between the pipeline (master) and the hazard unit (slave).
interface hazard_if #(
  parameter int RA_W = 5
);
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [RA_W-1:0] mem_rd;
  logic            mem_reg_write;
  logic            redirect;
  logic            mem_req;
  logic            mem_ready;

  logic            stall;
  logic            freeze;
  logic            flush_ifid;
  logic            flush_idex;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, redirect, mem_req, mem_ready,
    input  stall, freeze, flush_ifid, flush_idex, fwd_a, fwd_b, timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, redirect, mem_req, mem_ready,
    output stall, freeze, flush_ifid, flush_idex, fwd_a, fwd_b, timeout
  );
endinterface

// File: rtl/fwd_select.sv
// Operand forwarding select for one source register; the younger EX_MEM
// result wins over MEM_WB, and x0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_we,
  output logic [1:0]      fwd
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fwd = FWD_RF;
    if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
      fwd = FWD_EXMEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
      fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use / memory-wait / redirect hazard controller: a 4-state FSM sequences
// stall and flush windows; forwarding selects are decoded alongside.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int WAIT_MAX     = 15
) (
  input  logic clk,
  input  logic rst,
  hazard_if.slave hz
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_FIRST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LIM    = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             pend_q, pend_d;
  logic             timeout_q, timeout_d;
  logic [RA_W-1:0]  wb_rd_q;
  logic             wb_we_q;

  logic stall_c, freeze_c, flush_ifid_c, flush_idex_c;
  logic [1:0] fwd_a_c, fwd_b_c;
  logic load_use, mem_stall;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
  assign mem_stall = hz.mem_req && !hz.mem_ready;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pend_d       = pend_q;
    timeout_d    = timeout_q;
    stall_c      = 1'b0;
    freeze_c     = 1'b0;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;

    unique case (state_q)
      RUN, LOAD_STALL: begin
        if (state_q == LOAD_STALL) state_d = RUN;
        if (state_q == RUN && mem_stall) begin
          stall_c    = 1'b1;
          freeze_c   = 1'b1;
          state_d    = MEM_WAIT;
          pend_d     = hz.redirect;
          wait_cnt_d = CNT_W'(1);
        end else if (hz.redirect) begin
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_FIRST;
          end
        end else if (state_q == RUN && load_use) begin
          // One bubble: hold IF_ID, squash ID_EX; the load then forwards from EX_MEM.
          stall_c      = 1'b1;
          flush_idex_c = 1'b1;
          state_d      = LOAD_STALL;
        end
      end

      MEM_WAIT: begin
        if (!hz.mem_ready) begin
          stall_c    = 1'b1;
          freeze_c   = 1'b1;
          pend_d     = pend_q | hz.redirect;
          wait_cnt_d = (wait_cnt_q == CNT_SAT) ? CNT_SAT : wait_cnt_q + 1'b1;
        end else begin
          wait_cnt_d = '0;
          pend_d     = 1'b0;
          if (pend_q || hz.redirect) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d = RUN;
          end
        end
      end

      FLUSH: begin
        if (mem_stall) begin
          // Memory wait pre-empts the flush; the rest of it is replayed afterwards.
          stall_c     = 1'b1;
          freeze_c    = 1'b1;
          state_d     = MEM_WAIT;
          pend_d      = 1'b1;
          wait_cnt_d  = CNT_W'(1);
          flush_cnt_d = '0;
        end else begin
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          if (hz.redirect) begin
            flush_cnt_d = FLUSH_LOAD;
          end else if (flush_cnt_q <= CNT_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
      end

      default: state_d = RUN;
    endcase

    if (state_d == MEM_WAIT && wait_cnt_d >= WAIT_LIM) timeout_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
      timeout_q   <= 1'b0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
      timeout_q   <= timeout_d;
      if (!freeze_c) begin
        wb_rd_q <= hz.mem_rd;
        wb_we_q <= hz.mem_reg_write;
      end
    end
  end

  fwd_select #(.RA_W(RA_W)) u_fwd_a (
    .rs(hz.id_rs1), .mem_rd(hz.mem_rd), .mem_we(hz.mem_reg_write),
    .wb_rd(wb_rd_q), .wb_we(wb_we_q), .fwd(fwd_a_c)
  );

  fwd_select #(.RA_W(RA_W)) u_fwd_b (
    .rs(hz.id_rs2), .mem_rd(hz.mem_rd), .mem_we(hz.mem_reg_write),
    .wb_rd(wb_rd_q), .wb_we(wb_we_q), .fwd(fwd_b_c)
  );

  // Outputs are forced quiet while reset is held, not just after it.
  assign hz.stall      = stall_c      & ~rst;
  assign hz.freeze     = freeze_c     & ~rst;
  assign hz.flush_ifid = flush_ifid_c & ~rst;
  assign hz.flush_idex = flush_idex_c & ~rst;
  assign hz.fwd_a      = rst ? FWD_RF : fwd_a_c;
  assign hz.fwd_b      = rst ? FWD_RF : fwd_b_c;
  assign hz.timeout    = timeout_q    & ~rst;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: single-cycle vector table from a clean RUN
// state, plus hand-written multi-cycle window sequences.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_if #(.RA_W(5)) hz ();

  hazard_unit #(.RA_W(5), .FLUSH_CYCLES(2), .WAIT_MAX(15)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  // Output word: {stall, freeze, flush_ifid, flush_idex, fwd_a[1:0], fwd_b[1:0], timeout}
  localparam logic [8:0] IDLE    = 9'b0_0_0_0_00_00_0;
  localparam logic [8:0] LU      = 9'b1_0_0_1_00_00_0;
  localparam logic [8:0] FL      = 9'b0_0_1_1_00_00_0;
  localparam logic [8:0] MW      = 9'b1_1_0_0_00_00_0;
  localparam logic [8:0] FA_EX   = 9'b0_0_0_0_10_00_0;
  localparam logic [8:0] FA_WB   = 9'b0_0_0_0_01_00_0;
  localparam logic [8:0] FB_WB   = 9'b0_0_0_0_00_01_0;
  localparam logic [8:0] FAB_EX  = 9'b0_0_0_0_10_10_0;
  localparam logic [8:0] MW_FAEX = 9'b1_1_0_0_10_00_0;
  localparam logic [8:0] MW_FAWB = 9'b1_1_0_0_01_00_0;
  localparam logic [8:0] TO      = 9'b0_0_0_0_00_00_1;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] ex_rd;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic       redir;
    logic       mreq;
    logic       mrdy;
    logic [4:0] prime_rd;
    logic       prime_we;
    logic [8:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] ex_rd, logic ex_ld, logic [4:0] mem_rd, logic mem_we,
                              logic redir, logic mreq, logic mrdy,
                              logic [4:0] prime_rd, logic prime_we, logic [8:0] exp);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.ex_rd = ex_rd; v.ex_ld = ex_ld; v.mem_rd = mem_rd; v.mem_we = mem_we;
    v.redir = redir; v.mreq = mreq; v.mrdy = mrdy;
    v.prime_rd = prime_rd; v.prime_we = prime_we; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {hz.stall, hz.freeze, hz.flush_ifid, hz.flush_idex, hz.fwd_a, hz.fwd_b, hz.timeout};
  endfunction

  task automatic check(string name, logic [8:0] got, logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (stall,freeze,fl_ifid,fl_idex,fwd_a,fwd_b,timeout)",
               name, got, exp);
    end
  endtask

  task automatic neutral();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_reg_write = 1'b0; hz.ex_mem_read = 1'b0;
    hz.mem_rd = '0; hz.mem_reg_write = 1'b0;
    hz.redirect = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
  endtask

  // Check the current cycle's outputs mid-cycle, then advance to just after the next edge.
  task automatic step(string name, logic [8:0] exp);
    #2;
    check(name, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    neutral();
    step("reset_outputs", IDLE);
    rst = 1'b0;
  endtask

  task automatic drive(vec_t v);
    hz.id_rs1 = v.rs1; hz.id_use_rs1 = v.u1; hz.id_rs2 = v.rs2; hz.id_use_rs2 = v.u2;
    hz.ex_rd = v.ex_rd; hz.ex_reg_write = (v.ex_rd != 5'd0); hz.ex_mem_read = v.ex_ld;
    hz.mem_rd = v.mem_rd; hz.mem_reg_write = v.mem_we;
    hz.redirect = v.redir; hz.mem_req = v.mreq; hz.mem_ready = v.mrdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                name            rs1 u1 rs2 u2 exrd ld memrd we rd mq mr prd pwe exp
    vq.push_back(mk("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    vq.push_back(mk("lu_rs1",         5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, LU));
    vq.push_back(mk("lu_rs2",         0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, LU));
    vq.push_back(mk("lu_rs1_unused",  5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, IDLE));
    vq.push_back(mk("lu_x0",          0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, IDLE));
    vq.push_back(mk("alu_no_stall",   5, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    vq.push_back(mk("fwd_a_exmem",    3, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, FA_EX));
    vq.push_back(mk("fwd_b_memwb",    0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 4, 1, FB_WB));
    vq.push_back(mk("fwd_a_memwb",    4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, FA_WB));
    vq.push_back(mk("fwd_both_exmem", 3, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 3, 1, FA_EX));
    vq.push_back(mk("fwd_x0",         0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, IDLE));
    vq.push_back(mk("fwd_no_we",      3, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, IDLE));
    vq.push_back(mk("fwd_wb_no_we",   0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0, IDLE));
    vq.push_back(mk("fwd_ab_exmem",   6, 1, 6, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, FAB_EX));
    vq.push_back(mk("redirect",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, FL));
    vq.push_back(mk("mem_wait_fwd",   3, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, MW_FAEX));
    vq.push_back(mk("mem_ready",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, IDLE));
    vq.push_back(mk("prio_mw",        5, 1, 0, 0, 5, 1, 0, 0, 1, 1, 0, 0, 0, MW));
    vq.push_back(mk("prio_redir",     5, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0, FL));

    neutral();
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      do_reset();
      neutral();
      hz.mem_rd = vq[i].prime_rd;
      hz.mem_reg_write = vq[i].prime_we;
      @(posedge clk);
      #1;
      drive(vq[i]);
      step(vq[i].name, vq[i].exp);
    end

    // Load-use: one bubble, then the load is forwarded from EX_MEM.
    do_reset();
    hz.ex_rd = 5; hz.ex_reg_write = 1; hz.ex_mem_read = 1; hz.id_rs1 = 5; hz.id_use_rs1 = 1;
    step("s1_bubble", LU);
    hz.ex_rd = 0; hz.ex_reg_write = 0; hz.ex_mem_read = 0; hz.mem_rd = 5; hz.mem_reg_write = 1;
    step("s1_fwd_after_bubble", FA_EX);
    neutral();
    step("s1_idle", IDLE);

    // Redirect pulse: exactly two flush cycles.
    do_reset();
    hz.redirect = 1;
    step("s2_flush0", FL);
    hz.redirect = 0;
    step("s2_flush1", FL);
    step("s2_done", IDLE);

    // Memory wait with a redirect mid-wait: three stall cycles, ready, then two flush cycles.
    do_reset();
    hz.mem_req = 1; hz.mem_ready = 0;
    step("s3_wait0", MW);
    hz.redirect = 1;
    step("s3_wait1", MW);
    hz.redirect = 0;
    step("s3_wait2", MW);
    hz.mem_ready = 1;
    step("s3_ready", IDLE);
    hz.mem_req = 0; hz.mem_ready = 0;
    step("s3_flush0", FL);
    step("s3_flush1", FL);
    step("s3_done", IDLE);

    // Watchdog: 20 cycles without ready; timeout rises at cycle 15 (cycle 0 = request) and sticks.
    do_reset();
    hz.mem_req = 1; hz.mem_ready = 0;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("s4_wait%0d", i), (i >= 15) ? (MW | TO) : MW);
    end
    hz.mem_ready = 1;
    step("s4_ready", TO);
    hz.mem_req = 0; hz.mem_ready = 0;
    step("s4_sticky", TO);
    rst = 1;
    step("s4_in_reset", IDLE);
    rst = 0;
    step("s4_cleared", IDLE);

    // Memory wait during FLUSH defers the flush, which replays in full afterwards.
    do_reset();
    hz.redirect = 1;
    step("s7_flush0", FL);
    hz.redirect = 0; hz.mem_req = 1; hz.mem_ready = 0;
    step("s7_preempt", MW);
    hz.mem_ready = 1;
    step("s7_ready", IDLE);
    hz.mem_req = 0; hz.mem_ready = 0;
    step("s7_replay0", FL);
    step("s7_replay1", FL);
    step("s7_done", IDLE);

    // MEM_WB tracking holds while frozen.
    do_reset();
    hz.mem_rd = 9; hz.mem_reg_write = 1;
    step("s8_prime", IDLE);
    hz.mem_rd = 10; hz.id_rs1 = 9; hz.id_use_rs1 = 1; hz.mem_req = 1; hz.mem_ready = 0;
    step("s8_frozen0", MW_FAWB);
    step("s8_frozen1", MW_FAWB);
    hz.mem_ready = 1;
    step("s8_release", FA_WB);

    // Reset asserted mid-flush aborts the window; a later redirect behaves normally.
    do_reset();
    hz.redirect = 1;
    step("s6_flush0", FL);
    hz.redirect = 0;
    rst = 1;
    step("s6_rst_in_flush", IDLE);
    rst = 0;
    step("s6_after_rst", IDLE);
    hz.redirect = 1;
    step("s6_redir0", FL);
    hz.redirect = 0;
    step("s6_redir1", FL);
    step("s6_done", IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
